// File: rtl/mpc_mul_pkg.sv
// Shared constants and tag type for the MPC multiplier-sharing datapath.
package mpc_mul_pkg;
    localparam int A_W         = 21;
    localparam int B_W         = 8;
    localparam int P_W         = 30;
    localparam int MUL_LATENCY = 3;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_IDW     = 3;

    typedef struct packed {
        logic               vld;
        logic [TAG_IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/mpc_mul_pipe_21x8.sv
// DSP-style 21x8 multiplier: operand regs, product reg, output reg, all gated by ce.
module mpc_mul_pipe_21x8
    import mpc_mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  ce,
    input  logic signed [A_W-1:0] a,
    input  logic        [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);
    logic signed [A_W-1:0] a_r;
    logic        [B_W-1:0] b_r;
    logic signed [P_W-1:0] m_r;
    logic signed [P_W-1:0] p_r;

    // b is unsigned: zero-extend before the signed multiply so 255 stays 255.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_r <= a;
            b_r <= b;
            m_r <= $signed({{(P_W-A_W){a_r[A_W-1]}}, a_r}) *
                   $signed({{(P_W-B_W){1'b0}}, b_r});
            p_r <= m_r;
        end
    end

    assign p = p_r;
endmodule

// File: rtl/mpc_mul_share_arb.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters,
// with a tag pipe carrying the requester id alongside the product.
module mpc_mul_share_arb
    import mpc_mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*A_W-1:0]      req_a,
    input  logic [NREQ*B_W-1:0]      req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [IDW-1:0]           res_id,
    output logic signed [P_W-1:0]    res_p,
    output logic                     busy
);
    logic                    ce;
    logic                    issue;
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          grant;
    logic signed [A_W-1:0]   a_sel;
    logic [B_W-1:0]          b_sel;
    logic [LATENCY-1:0]      tag_vld;
    tag_t [LATENCY-1:0]      tag_q;

    // First valid requester strictly after ptr, wrapping; returns ptr when none valid.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  p);
        logic found;
        int   idx;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && v[idx]) begin
                rr_pick = IDW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    assign res_valid = tag_q[LATENCY-1].vld;
    assign res_id    = tag_q[LATENCY-1].id[IDW-1:0];
    assign ce        = !(res_valid && !res_ready);
    assign grant     = rr_pick(req_valid, ptr_q);
    assign issue     = ce && (|req_valid);
    assign a_sel     = req_a[A_W*int'(grant) +: A_W];
    assign b_sel     = req_b[B_W*int'(grant) +: B_W];

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[grant] = 1'b1;
    end

    always_comb begin
        tag_vld = '0;
        for (int i = 0; i < LATENCY; i++) tag_vld[i] = tag_q[i].vld;
    end
    assign busy = |tag_vld;

    // Tag pipe and pointer freeze together with the multiplier on ce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
            ptr_q <= IDW'(NREQ-1);
        end else if (ce) begin
            tag_q[0] <= tag_t'{vld: issue, id: TAG_IDW'(grant)};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
            if (issue) ptr_q <= grant;
        end
    end

    generate
        if (TAG_IDW > IDW) begin : g_id_pad
            logic unused_id_bits;
            assign unused_id_bits = ^tag_q[LATENCY-1].id[TAG_IDW-1:IDW];
        end
    endgenerate

    mpc_mul_pipe_21x8 u_mul (
        .clk (clk),
        .ce  (ce),
        .a   (a_sel),
        .b   (b_sel),
        .p   (res_p)
    );
endmodule

// File: tb/tb_mpc_mul_share_arb.sv
// Directed self-checking bench for mpc_mul_share_arb (NREQ=4, latency 3).
module tb_mpc_mul_share_arb;
    localparam int NREQ = 4;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*21-1:0] req_a;
    logic [NREQ*8-1:0]  req_b;
    logic               res_valid;
    logic               res_ready;
    logic [1:0]         res_id;
    logic signed [29:0] res_p;
    logic               busy;

    int checks = 0;
    int errors = 0;

    mpc_mul_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[21*i +: 21] = 21'(a);
        req_b[8*i +: 8]   = 8'(b);
    endtask

    task automatic chk_res(input string tag, input int id, input int p);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_id"},    32'(res_id),    32'(id));
        chk({tag, "_p"},     32'(res_p),     32'(p));
    endtask

    int prods [4] = '{20, -60, 1200, -20000};

    initial begin
        rst       = 1'b0;
        res_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #2;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        #10 rst = 1'b1;

        // 1: single issue at the negative extreme
        req_valid = 4'b0001;
        set_op(0, -1048576, 255);
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_lat1", 32'(res_valid), 32'd0);
        tick();
        chk("t1_lat2", 32'(res_valid), 32'd0);
        tick();
        chk_res("t1", 0, -267386880);

        // 2: back-to-back on requester 1
        req_valid = 4'b0010;
        set_op(1, 1048575, 255);
        #1 chk("t2_ready0", 32'(req_ready), 32'h2);
        tick();
        set_op(1, 3, 7);
        #1 chk("t2_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk_res("t2_r0", 1, 267386625);
        tick();
        chk_res("t2_r1", 1, 21);
        tick();
        chk("t2_drain_valid", 32'(res_valid), 32'd0);
        chk("t2_drain_busy",  32'(busy),      32'd0);

        // 3: fairness from a fresh pointer
        rst = 1'b0;
        #1 chk("t3_rst_valid", 32'(res_valid), 32'd0);
        rst = 1'b1;
        set_op(0, 10, 2);
        set_op(1, -20, 3);
        set_op(2, 300, 4);
        set_op(3, -4000, 5);
        for (int k = 0; k <= 10; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) chk("t3_ready", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 3) chk_res("t3_res", (k - 3) % 4, prods[(k - 3) % 4]);
            tick();
        end

        // 4: backpressure holds the tail and blocks new grants
        req_valid = 4'b0001;
        set_op(0, 100, 3);
        #1 chk("t4_ready_a", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        set_op(1, -7, 9);
        #1 chk("t4_ready_b", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        res_ready = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 5, 5);
        for (int s = 0; s < 5; s++) begin
            #1;
            chk_res("t4_hold", 0, 300);
            chk("t4_stall_ready", 32'(req_ready), 32'h0);
            tick();
        end
        res_ready = 1'b1;
        #1 chk("t4_release_ready", 32'(req_ready), 32'h4);
        chk_res("t4_release", 0, 300);
        tick();
        req_valid = '0;
        chk_res("t4_b", 1, -63);
        tick();
        chk("t4_gap", 32'(res_valid), 32'd0);
        tick();
        chk_res("t4_c", 2, 25);
        tick();
        chk("t4_end_valid", 32'(res_valid), 32'd0);
        chk("t4_end_busy",  32'(busy),      32'd0);

        // 5: requests on alternate cycles produce alternating results
        for (int k = 0; k <= 8; k++) begin
            req_valid = (k % 2 == 0 && k <= 4) ? 4'b1000 : 4'b0000;
            set_op(3, -(k + 1) * 1000, 200);
            #1;
            if (req_valid != 0) chk("t5_ready", 32'(req_ready), 32'h8);
            if (k >= 1 && k <= 7) chk("t5_busy", 32'(busy), 32'd1);
            if (k >= 3) begin
                chk("t5_valid", 32'(res_valid), 32'(k % 2 == 1 && k <= 7));
                if (k % 2 == 1 && k <= 7) chk_res("t5_res", 3, -(k - 2) * 200000);
            end
            tick();
        end
        chk("t5_end_busy", 32'(busy), 32'd0);

        // 6: reset with two results in flight
        req_valid = 4'b0001;
        set_op(0, 1, 1);
        #1 chk("t6_ready_a", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        set_op(1, 2, 2);
        #1 chk("t6_ready_b", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk("t6_pre_valid", 32'(res_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(res_valid), 32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        tick();
        tick();
        #2 rst = 1'b1;
        req_valid = 4'b0101;
        set_op(0, 11, 3);
        set_op(2, 7, 4);
        #1;
        chk("t6_first_grant", 32'(req_ready), 32'h1);
        chk("t6_no_stale",    32'(res_valid), 32'd0);
        tick();
        chk("t6_second_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("t6_no_stale2", 32'(res_valid), 32'd0);
        tick();
        chk_res("t6_r0", 0, 33);
        tick();
        chk_res("t6_r2", 2, 28);
        tick();
        chk("t6_end_valid", 32'(res_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
